miter_seq_checker: RTL and testbench

Parametrised, clocked gold-vs-gate comparator for the equivalence-check partitions of `jpeg_encoder`. It generalises the single-bit combinational miter into a monitor that does the following:
- compares WIDTH-bit gold and gate buses on every valid sample, honouring a per-bit care mask;
- counts samples and mismatches;
- captures the first failing sample;
- hands that capture to a reporting agent over a valid/ready handshake.

It sits beside the gold/gate instances in simulation and emulation benches, where X-based don't-care is not available.

---
 rtl/miter_seq_checker.sv | 112 +++++++++++
 tb/tb_miter_seq_checker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/miter_seq_checker.sv
// Clocked gold-vs-gate miter: masked compare, saturating counters, first-failure capture
// with a valid/ready report port. Define MITER_ASSERT_EN to assert on every mismatch pulse.
module miter_seq_checker #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_gold,
  input  logic [WIDTH-1:0] in_gate,
  input  logic [WIDTH-1:0] in_care,
  output logic             mismatch,
  output logic             fail,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_index,
  output logic [WIDTH-1:0] rpt_diff
);

  typedef enum logic [1:0] {IDLE, RUN, REPORT, LATCHED} state_t;

  state_t           state;
  state_t           resume;
  state_t           cur;
  state_t           nxt;
  logic [WIDTH-1:0] diff;
  logic             sample;
  logic             bad;
  logic             accept;

  // While disabled, state parks in IDLE and resume remembers where to pick up,
  // so a re-enabled cycle already compares in the restored state.
  always_comb begin
    diff   = (in_gold ^ in_gate) & in_care;
    sample = in_valid & en;
    bad    = sample & (|diff);
    cur    = (state == IDLE) ? resume : state;
    accept = en & (cur == REPORT) & rpt_valid & rpt_ready;
    nxt    = cur;
    if (en) begin
      if (cur == RUN && bad)
        nxt = REPORT;
      else if (accept)
        nxt = LATCHED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      resume         <= RUN;
      mismatch       <= 1'b0;
      fail           <= 1'b0;
      sample_count   <= '0;
      mismatch_count <= '0;
      rpt_valid      <= 1'b0;
      rpt_index      <= '0;
      rpt_diff       <= '0;
    end else if (clear) begin
      state          <= en ? RUN : IDLE;
      resume         <= RUN;
      mismatch       <= 1'b0;
      fail           <= 1'b0;
      sample_count   <= '0;
      mismatch_count <= '0;
      rpt_valid      <= 1'b0;
      rpt_index      <= '0;
      rpt_diff       <= '0;
    end else begin
      state    <= en ? nxt : IDLE;
      resume   <= nxt;
      mismatch <= bad;
      if (bad)
        fail <= 1'b1;
      if (sample && sample_count != '1)
        sample_count <= sample_count + 1'b1;
      if (bad && mismatch_count != '1)
        mismatch_count <= mismatch_count + 1'b1;
      if (bad && cur == RUN) begin
        rpt_valid <= 1'b1;
        rpt_index <= sample_count;
        rpt_diff  <= diff;
      end
      if (accept)
        rpt_valid <= 1'b0;
    end
  end

`ifdef MITER_ASSERT_EN
  logic [WIDTH-1:0] last_diff;
  logic [CNT_W-1:0] last_index;

  always_ff @(posedge clk) begin
    if (bad) begin
      last_diff  <= diff;
      last_index <= sample_count;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      assert (!mismatch)
      else $error("miter mismatch: diff=%h index=%0d", last_diff, last_index);
  end
`endif

endmodule

// File: tb/tb_miter_seq_checker.sv
// Directed bench for miter_seq_checker: a 32-bit instance for the main scenarios and a
// 4-bit-counter instance for saturation.
module tb_miter_seq_checker;

  logic        clk = 1'b0;
  logic        rst, en, clear, rpt_ready;
  logic        in_valid;
  logic [31:0] in_gold, in_gate, in_care;
  logic        mismatch, fail, rpt_valid;
  logic [15:0] sample_count, mismatch_count, rpt_index;
  logic [31:0] rpt_diff;

  logic        v1;
  logic [7:0]  gold1, gate1, care1;
  logic        mm1, fail1, rv1;
  logic [3:0]  sc1, mc1, ri1;
  logic [7:0]  rd1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  miter_seq_checker #(.WIDTH(32), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .in_valid(in_valid), .in_gold(in_gold), .in_gate(in_gate), .in_care(in_care),
    .mismatch(mismatch), .fail(fail), .sample_count(sample_count),
    .mismatch_count(mismatch_count), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_index(rpt_index), .rpt_diff(rpt_diff)
  );

  miter_seq_checker #(.WIDTH(8), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .in_valid(v1), .in_gold(gold1), .in_gate(gate1), .in_care(care1),
    .mismatch(mm1), .fail(fail1), .sample_count(sc1),
    .mismatch_count(mc1), .rpt_valid(rv1), .rpt_ready(rpt_ready),
    .rpt_index(ri1), .rpt_diff(rd1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] gate, input logic [31:0] care);
    in_valid = v;
    in_gold  = 32'hA5A5A5A5;
    in_gate  = gate;
    in_care  = care;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clear = 1'b0; rpt_ready = 1'b0;
    drive(1'b0, 32'hA5A5A5A5, 32'hFFFFFFFF);
    v1 = 1'b0; gold1 = 8'h00; gate1 = 8'h00; care1 = 8'hFF;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch: got %0h want 0", mismatch); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %0h want 0", fail); end
    checks++; if (sample_count !== 16'd0) begin errors++; $display("FAIL reset_sample_count: got %0d want 0", sample_count); end
    checks++; if (mismatch_count !== 16'd0) begin errors++; $display("FAIL reset_mismatch_count: got %0d want 0", mismatch_count); end
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL reset_rpt_valid: got %0h want 0", rpt_valid); end
    checks++; if (rpt_index !== 16'd0) begin errors++; $display("FAIL reset_rpt_index: got %0d want 0", rpt_index); end
    checks++; if (rpt_diff !== 32'd0) begin errors++; $display("FAIL reset_rpt_diff: got %0h want 0", rpt_diff); end
  endtask

  task automatic test_clean();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'hA5A5A5A5, 32'hFFFFFFFF);
      tick();
    end
    drive(1'b0, 32'hA5A5A5A5, 32'hFFFFFFFF);
    tick();
    checks++; if (sample_count !== 16'd10) begin errors++; $display("FAIL clean_sample_count: got %0d want 10", sample_count); end
    checks++; if (mismatch_count !== 16'd0) begin errors++; $display("FAIL clean_mismatch_count: got %0d want 0", mismatch_count); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL clean_fail: got %0h want 0", fail); end
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL clean_rpt_valid: got %0h want 0", rpt_valid); end
  endtask

  task automatic test_first_fail();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA5A5A5A5, 32'hFFFFFFFF);
      tick();
    end
    drive(1'b1, 32'hA5A5A5A4, 32'hFFFFFFFF);
    tick();
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL first_mismatch: got %0h want 1", mismatch); end
    checks++; if (fail !== 1'b1) begin errors++; $display("FAIL first_fail: got %0h want 1", fail); end
    checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL first_rpt_valid: got %0h want 1", rpt_valid); end
    checks++; if (rpt_index !== 16'd3) begin errors++; $display("FAIL first_rpt_index: got %0d want 3", rpt_index); end
    checks++; if (rpt_diff !== 32'h00000001) begin errors++; $display("FAIL first_rpt_diff: got %0h want 1", rpt_diff); end
    drive(1'b1, 32'hA5A5A5A5, 32'hFFFFFFFF);
    tick();
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL first_pulse_width: got %0h want 0", mismatch); end
    checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL first_rpt_hold: got %0h want 1", rpt_valid); end
    drive(1'b0, 32'hA5A5A5A5, 32'hFFFFFFFF);
    tick();
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL handshake_rpt_valid: got %0h want 0", rpt_valid); end
    drive(1'b1, 32'h00000000, 32'hFFFFFFFF);
    tick();
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL latched_mismatch: got %0h want 1", mismatch); end
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL latched_no_recapture: got %0h want 0", rpt_valid); end
    checks++; if (rpt_index !== 16'd3) begin errors++; $display("FAIL latched_rpt_index: got %0d want 3", rpt_index); end
    checks++; if (mismatch_count !== 16'd2) begin errors++; $display("FAIL latched_mismatch_count: got %0d want 2", mismatch_count); end
    checks++; if (sample_count !== 16'd6) begin errors++; $display("FAIL latched_sample_count: got %0d want 6", sample_count); end
  endtask

  task automatic test_care_mask();
    drive(1'b1, 32'h25A5A5A5, 32'h7FFFFFFF);
    tick();
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL care_mismatch: got %0h want 0", mismatch); end
    checks++; if (mismatch_count !== 16'd2) begin errors++; $display("FAIL care_mismatch_count: got %0d want 2", mismatch_count); end
    checks++; if (sample_count !== 16'd7) begin errors++; $display("FAIL care_sample_count: got %0d want 7", sample_count); end
    drive(1'b1, 32'h5A5A5A5A, 32'h00000000);
    tick();
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL care_zero_mismatch: got %0h want 0", mismatch); end
    checks++; if (sample_count !== 16'd8) begin errors++; $display("FAIL care_zero_sample_count: got %0d want 8", sample_count); end
    drive(1'b0, 32'hA5A5A5A5, 32'hFFFFFFFF);
  endtask

  task automatic test_saturation();
    do_reset();
    en = 1'b1;
    v1 = 1'b1; gold1 = 8'h00; gate1 = 8'hFF; care1 = 8'hFF;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (sc1 !== 4'd15) begin errors++; $display("FAIL sat_sample_at_15: got %0d want 15", sc1); end
    for (int i = 0; i < 5; i++) tick();
    v1 = 1'b0;
    tick();
    checks++; if (mc1 !== 4'd15) begin errors++; $display("FAIL sat_mismatch_count: got %0d want 15", mc1); end
    checks++; if (sc1 !== 4'd15) begin errors++; $display("FAIL sat_sample_count: got %0d want 15", sc1); end
    checks++; if (ri1 !== 4'd0) begin errors++; $display("FAIL sat_rpt_index: got %0d want 0", ri1); end
    checks++; if (rd1 !== 8'hFF) begin errors++; $display("FAIL sat_rpt_diff: got %0h want ff", rd1); end
    checks++; if (rv1 !== 1'b1) begin errors++; $display("FAIL sat_rpt_valid: got %0h want 1", rv1); end
  endtask

  task automatic test_clear();
    do_reset();
    en = 1'b1;
    drive(1'b1, 32'hA5A5A5A5, 32'hFFFFFFFF); tick(); tick();
    drive(1'b1, 32'h00000000, 32'hFFFFFFFF); tick();
    checks++; if (rpt_index !== 16'd2) begin errors++; $display("FAIL clear_pre_index: got %0d want 2", rpt_index); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (sample_count !== 16'd0) begin errors++; $display("FAIL clear_sample_count: got %0d want 0", sample_count); end
    checks++; if (mismatch_count !== 16'd0) begin errors++; $display("FAIL clear_mismatch_count: got %0d want 0", mismatch_count); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL clear_fail: got %0h want 0", fail); end
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL clear_rpt_valid: got %0h want 0", rpt_valid); end
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL clear_mismatch: got %0h want 0", mismatch); end
    checks++; if (rpt_diff !== 32'd0) begin errors++; $display("FAIL clear_rpt_diff: got %0h want 0", rpt_diff); end
    drive(1'b1, 32'hA5A5A5B5, 32'hFFFFFFFF);
    tick();
    checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL recapture_rpt_valid: got %0h want 1", rpt_valid); end
    checks++; if (rpt_index !== 16'd0) begin errors++; $display("FAIL recapture_rpt_index: got %0d want 0", rpt_index); end
    checks++; if (rpt_diff !== 32'h00000010) begin errors++; $display("FAIL recapture_rpt_diff: got %0h want 10", rpt_diff); end
    checks++; if (sample_count !== 16'd1) begin errors++; $display("FAIL recapture_sample_count: got %0d want 1", sample_count); end
  endtask

  task automatic test_disable();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(((i % 2) == 0), 32'h00000000, 32'hFFFFFFFF);
      tick();
      checks++; if (sample_count !== 16'd1) begin errors++; $display("FAIL dis_sample_count[%0d]: got %0d want 1", i, sample_count); end
      checks++; if (mismatch_count !== 16'd1) begin errors++; $display("FAIL dis_mismatch_count[%0d]: got %0d want 1", i, mismatch_count); end
      checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL dis_mismatch[%0d]: got %0h want 0", i, mismatch); end
      checks++; if (fail !== 1'b1) begin errors++; $display("FAIL dis_fail[%0d]: got %0h want 1", i, fail); end
    end
    en = 1'b1;
    drive(1'b0, 32'hA5A5A5A5, 32'hFFFFFFFF);
    tick();
    checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL resume_rpt_valid: got %0h want 1", rpt_valid); end
    drive(1'b1, 32'hA5A5A5A4, 32'hFFFFFFFF);
    tick();
    checks++; if (mismatch_count !== 16'd2) begin errors++; $display("FAIL resume_mismatch_count: got %0d want 2", mismatch_count); end
    checks++; if (sample_count !== 16'd2) begin errors++; $display("FAIL resume_sample_count: got %0d want 2", sample_count); end
    checks++; if (rpt_index !== 16'd0) begin errors++; $display("FAIL resume_rpt_index: got %0d want 0", rpt_index); end
    checks++; if (rpt_diff !== 32'h00000010) begin errors++; $display("FAIL resume_rpt_diff: got %0h want 10", rpt_diff); end
  endtask

  task automatic test_back_to_back();
    rpt_ready = 1'b1;
    drive(1'b1, 32'hA5A5A5A7, 32'hFFFFFFFF);
    tick();
    rpt_ready = 1'b0;
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL b2b_rpt_valid: got %0h want 0", rpt_valid); end
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL b2b_mismatch: got %0h want 1", mismatch); end
    checks++; if (mismatch_count !== 16'd3) begin errors++; $display("FAIL b2b_mismatch_count: got %0d want 3", mismatch_count); end
    checks++; if (rpt_diff !== 32'h00000010) begin errors++; $display("FAIL b2b_rpt_diff: got %0h want 10", rpt_diff); end
    tick();
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL b2b_continuous: got %0h want 1", mismatch); end
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_recapture: got %0h want 0", rpt_valid); end
    checks++; if (mismatch_count !== 16'd4) begin errors++; $display("FAIL b2b_mismatch_count2: got %0d want 4", mismatch_count); end
    drive(1'b0, 32'hA5A5A5A5, 32'hFFFFFFFF);
    tick();
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL b2b_fall: got %0h want 0", mismatch); end
  endtask

  task automatic test_reset_mid_report();
    clear = 1'b1; tick(); clear = 1'b0;
    drive(1'b1, 32'h00000000, 32'hFFFFFFFF);
    tick();
    drive(1'b0, 32'hA5A5A5A5, 32'hFFFFFFFF);
    checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_rpt_valid: got %0h want 1", rpt_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL mid_rpt_valid: got %0h want 0", rpt_valid); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL mid_fail: got %0h want 0", fail); end
    checks++; if (sample_count !== 16'd0) begin errors++; $display("FAIL mid_sample_count: got %0d want 0", sample_count); end
    checks++; if (rpt_diff !== 32'd0) begin errors++; $display("FAIL mid_rpt_diff: got %0h want 0", rpt_diff); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_first_fail();
    test_care_mask();
    test_saturation();
    test_clear();
    test_disable();
    test_back_to_back();
    test_reset_mid_report();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
